// File: rtl/tx_frame_sched.sv
// tx_frame_sched: frame-level round-robin scheduler that shares the sender's
// single AXI-stream input between two requesters (0 = PS FIFO payload,
// 1 = link test / calibration frames).
//   - Whole frames are granted; a grant is registered in IDLE.
//   - A programmable idle guard gap follows every frame so the receiver's
//     m-sequence correlator can settle.
//   - Frames longer than MAX_BEATS are truncated: the last allowed beat is
//     marked tlast, and the rest of the source frame is drained.
// Ports:
//   clk, arst_n           clock, asynchronous active-low reset
//   en                    scheduler enable (sampled only in IDLE)
//   gap_cycles            guard gap length in cycles (stable while busy)
//   err_clr               pulse clearing trunc_err
//   S0_AXIS_*, S1_AXIS_*  requester AXI-stream slave ports
//   M_AXIS_*              master port towards the sender
//   grant                 current / last granted stream index
//   busy                  high outside IDLE
//   frame_cnt             completed frame counter (wraps)
//   trunc_err             sticky overlong-frame flag
module tx_frame_sched #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BEATS  = 1024,
    parameter int unsigned GAP_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         en,
    input  logic [GAP_WIDTH-1:0]         gap_cycles,
    input  logic                         err_clr,
    input  logic [DATA_WIDTH-1:0]        S0_AXIS_tdata,
    input  logic [(DATA_WIDTH>>3)-1:0]   S0_AXIS_tkeep,
    input  logic                         S0_AXIS_tlast,
    input  logic                         S0_AXIS_tvalid,
    output logic                         S0_AXIS_tready,
    input  logic [DATA_WIDTH-1:0]        S1_AXIS_tdata,
    input  logic [(DATA_WIDTH>>3)-1:0]   S1_AXIS_tkeep,
    input  logic                         S1_AXIS_tlast,
    input  logic                         S1_AXIS_tvalid,
    output logic                         S1_AXIS_tready,
    output logic [DATA_WIDTH-1:0]        M_AXIS_tdata,
    output logic [(DATA_WIDTH>>3)-1:0]   M_AXIS_tkeep,
    output logic                         M_AXIS_tlast,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic                         grant,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         frame_cnt,
    output logic                         trunc_err
);

    localparam int unsigned KEEP_W = DATA_WIDTH >> 3;
    localparam int unsigned BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_grant;
    logic [BEAT_W-1:0]      r_beat_cnt;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic [CNT_WIDTH-1:0]   r_frame_cnt;
    logic                   r_trunc_err;

    logic [DATA_WIDTH-1:0]  w_sel_tdata;
    logic [KEEP_W-1:0]      w_sel_tkeep;
    logic                   w_sel_tlast;
    logic                   w_sel_tvalid;
    logic                   w_sel_tready;
    logic                   w_in_send;
    logic                   w_in_drain;
    logic                   w_at_limit;
    logic                   w_m_hs;
    logic                   w_drain_hs;
    logic                   w_trunc;
    logic                   w_gap_zero;
    logic                   w_gap_done;
    logic                   w_any_req;
    logic                   w_next_grant;

    // Granted-source mux
    assign w_sel_tdata  = r_grant ? S1_AXIS_tdata  : S0_AXIS_tdata;
    assign w_sel_tkeep  = r_grant ? S1_AXIS_tkeep  : S0_AXIS_tkeep;
    assign w_sel_tlast  = r_grant ? S1_AXIS_tlast  : S0_AXIS_tlast;
    assign w_sel_tvalid = r_grant ? S1_AXIS_tvalid : S0_AXIS_tvalid;

    assign w_in_send  = (r_state == S_SEND);
    assign w_in_drain = (r_state == S_DRAIN);
    assign w_at_limit = (r_beat_cnt == LAST_BEAT);

    // Zero-latency pass-through in SEND; the last allowed beat is forced to tlast
    assign M_AXIS_tvalid = w_in_send & w_sel_tvalid;
    assign M_AXIS_tdata  = w_in_send ? w_sel_tdata : '0;
    assign M_AXIS_tkeep  = w_in_send ? w_sel_tkeep : '0;
    assign M_AXIS_tlast  = w_in_send & (w_sel_tlast | w_at_limit);

    // DRAIN accepts unconditionally to discard the overlong tail
    assign w_sel_tready   = (w_in_send & M_AXIS_tready) | w_in_drain;
    assign S0_AXIS_tready = ~r_grant & w_sel_tready;
    assign S1_AXIS_tready =  r_grant & w_sel_tready;

    assign w_m_hs     = M_AXIS_tvalid & M_AXIS_tready;
    assign w_drain_hs = w_in_drain & w_sel_tvalid;
    assign w_trunc    = w_m_hs & w_at_limit & ~w_sel_tlast;
    assign w_gap_zero = (gap_cycles == '0);
    assign w_gap_done = (r_gap_cnt == (gap_cycles - GAP_WIDTH'(1)));

    // Only one valid wins outright; a tie goes to the stream not granted last
    assign w_any_req    = S0_AXIS_tvalid | S1_AXIS_tvalid;
    assign w_next_grant = (S0_AXIS_tvalid & S1_AXIS_tvalid) ? ~r_grant : S1_AXIS_tvalid;

    assign grant     = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign frame_cnt = r_frame_cnt;
    assign trunc_err = r_trunc_err;

    // Scheduler state machine and status registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= 1'b1;
            r_beat_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_frame_cnt <= '0;
            r_trunc_err <= 1'b0;
        end else begin
            // Truncation takes priority over a coincident clear
            if (w_trunc) begin
                r_trunc_err <= 1'b1;
            end else if (err_clr) begin
                r_trunc_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (en && w_any_req) begin
                        r_grant <= w_next_grant;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_m_hs) begin
                        if (w_sel_tlast || w_at_limit) begin
                            r_beat_cnt  <= '0;
                            r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                            if (w_trunc) begin
                                r_state <= S_DRAIN;
                            end else if (w_gap_zero) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_hs && w_sel_tlast) begin
                        r_state <= w_gap_zero ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
- Frame-level scheduler in front of the transmit-side sender datapath (PAM map plus frame-head insertion).
- Shares the sender's single AXI-stream input between two requesters:
  - stream 0: payload data from the PS FIFO.
  - stream 1: link test / calibration frames.
- Grants whole frames round-robin and inserts a programmable idle guard gap between frames so the receiver's m-sequence correlator settles.
- Polices maximum frame length and exports frame/error status.

Parameters:
- DATA_WIDTH, 32, AXI-stream tdata width; tkeep width is DATA_WIDTH>>3.
- MAX_BEATS, 1024, maximum beats per frame before forced truncation.
- GAP_WIDTH, 8, width of the guard-gap configuration input.
- CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; sampled only in IDLE.
- gap_cycles  in  GAP_WIDTH  idle cycles inserted after each frame; must be held stable while busy.
- err_clr  in  1  one-cycle pulse that clears trunc_err.
- S0_AXIS_tdata / S1_AXIS_tdata  in  DATA_WIDTH  requester data.
- S0_AXIS_tkeep / S1_AXIS_tkeep  in  DATA_WIDTH>>3  requester byte enables.
- S0_AXIS_tlast / S1_AXIS_tlast  in  1  end of frame.
- S0_AXIS_tvalid / S1_AXIS_tvalid  in  1  requester valid.
- S0_AXIS_tready / S1_AXIS_tready  out  1  requester ready.
- M_AXIS_tdata  out  DATA_WIDTH  to sender input.
- M_AXIS_tkeep  out  DATA_WIDTH>>3  to sender input.
- M_AXIS_tlast  out  1  to sender input.
- M_AXIS_tvalid  out  1  to sender input.
- M_AXIS_tready  in  1  from sender.
- grant  out  1  index of the current or last granted stream.
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  CNT_WIDTH  completed frames, wraps at 2^CNT_WIDTH.
- trunc_err  out  1  sticky; set when a frame exceeds MAX_BEATS.

Behaviour:
- Reset values (arst_n low, asynchronous):
  - State = IDLE.
  - All tready and M_AXIS_tvalid = 0; M_AXIS_tlast = 0; M_AXIS_tdata/tkeep = 0.
  - grant = 1, so stream 0 wins the first tie.
  - busy = 0; frame_cnt = 0; trunc_err = 0.
  - Beat and gap counters = 0.
- States: IDLE, SEND, DRAIN, GAP.
- IDLE:
  - No tready asserted; M_AXIS_tvalid = 0.
  - If en=1 and any tvalid=1, register a new grant and go to SEND next cycle.
  - If only one requester is valid, it wins.
  - If both are valid, the stream != grant wins (round-robin).
  - Arbitration is registered: first beat can transfer no earlier than one cycle after tvalid is seen in IDLE.
- SEND: combinational pass-through, zero latency.
  - M_AXIS_tdata/tkeep/tlast/tvalid = granted S*_AXIS signals.
  - Granted tready = M_AXIS_tready; other tready = 0.
  - Beat counter increments on each M handshake.
  - Handshake with tlast=1: frame_cnt +1, beat counter cleared. Go to GAP if gap_cycles != 0, else IDLE.
  - Handshake at beat index MAX_BEATS-1 with source tlast=0:
    - M_AXIS_tlast forced to 1 on that beat; trunc_err set; frame_cnt +1.
    - Go to DRAIN.
- DRAIN: discards the remainder of the overlong frame.
  - Granted tready = 1; M_AXIS_tvalid = 0.
  - Source beats are discarded until a beat with tlast=1 is accepted.
  - Then go to GAP, or IDLE if gap_cycles = 0.
- GAP:
  - No tready asserted; M_AXIS_tvalid = 0.
  - Counter runs from 0 to gap_cycles-1, then returns to IDLE. Total gap in GAP state = gap_cycles cycles, plus the one-cycle IDLE arbitration.
- Enable:
  - en deasserted mid-frame does not abort: SEND/DRAIN/GAP complete normally.
  - No new grant is issued while en=0.
- Source and sink rules:
  - Source tvalid dropping mid-frame is legal; the scheduler simply waits.
  - The scheduler never drops tvalid once it has been presented to the sender without a handshake.
- trunc_err:
  - err_clr clears trunc_err.
  - If err_clr coincides with a new truncation event, set wins.
- frame_cnt wraps from all-ones to 0 with no flag.
- Single-beat frame (tlast on first beat) is legal: SEND lasts exactly one handshake.
- Reset mid-frame: immediate return to reset values. A partially sent frame is abandoned; the sender/frame-head logic is reset by the same arst_n.

Test Plan:
- S0 only, 4-beat frame, gap_cycles=3, M_AXIS_tready=1:
  - Beats appear on M_AXIS unchanged, tlast on beat 4.
  - Then 3 cycles of tvalid=0 in GAP, then 1 IDLE cycle.
  - frame_cnt=1, grant=0.
- S0 and S1 both continuously valid, 2-beat frames, gap_cycles=0: grant sequence 0,1,0,1; frame_cnt=4 after four frames; no beats interleaved within a frame.
- MAX_BEATS=8, S1 sends a 12-beat frame:
  - Beat 8 out with M_AXIS_tlast=1; trunc_err=1.
  - Beats 9-12 consumed with M_AXIS_tvalid=0.
  - err_clr pulse then returns trunc_err to 0.
- Backpressure: M_AXIS_tready toggles 1,0,0,1 during a frame:
  - S0_AXIS_tready mirrors it exactly.
  - M_AXIS_tdata holds stable while tvalid=1 and tready=0.
- en dropped during beat 2 of a 5-beat frame: all 5 beats still delivered, then the scheduler stays in IDLE with S1 valid until en returns.
- arst_n asserted during beat 3:
  - Next edge: all outputs at reset values, frame_cnt=0.
  - After release with S0 valid: first handshake occurs 1 cycle later.
